pipe_stage: RTL and testbench

Parametrised pipeline stage register for the in-order front end: a generalised replacement for the fixed IF/ID and ID/EX latches. It carries a payload plus an instruction tag across one stage with a valid/ready handshake, supports a global flush for jumps, and tracks back-pressure. An optional skid buffer allows full throughput with a registered `in_ready`.

---
 rtl/pipe_stage.sv | 133 +++++++++++++
 tb/tb_pipe_stage.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// Valid/ready pipeline stage carrying a payload and instruction tag, with flush and stall counting.
// Define PIPE_STAGE_SKID_EN for the 2-entry skid build with a registered in_ready.
module pipe_stage #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              flush,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state, state_nxt;
  logic              in_fire, out_fire, load_main;
  logic [DATA_W-1:0] main_data, main_data_nxt;
  logic [TAG_W-1:0]  main_tag, main_tag_nxt;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_valid = (state != EMPTY);
  assign occ       = state;
  assign out_data  = main_data;
  assign out_tag   = main_tag;

`ifdef PIPE_STAGE_SKID_EN
  logic              in_ready_q, load_skid;
  logic [DATA_W-1:0] skid_data;
  logic [TAG_W-1:0]  skid_tag;

  assign in_ready = in_ready_q;

  always_comb begin
    state_nxt     = state;
    load_main     = 1'b0;
    load_skid     = 1'b0;
    main_data_nxt = in_data;
    main_tag_nxt  = in_tag;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
        ONE: if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
        TWO: if (out_fire) begin
          load_main     = 1'b1;
          main_data_nxt = skid_data;
          main_tag_nxt  = skid_tag;
          state_nxt     = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready is derived from the next state so it never depends on out_ready combinationally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b1;
      skid_data  <= '0;
      skid_tag   <= '0;
    end else begin
      in_ready_q <= (state_nxt != TWO);
      if (load_skid) begin
        skid_data <= in_data;
        skid_tag  <= in_tag;
      end
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_comb begin
    state_nxt     = state;
    load_main     = 1'b0;
    main_data_nxt = in_data;
    main_tag_nxt  = in_tag;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (in_fire) begin
      load_main = 1'b1;
      state_nxt = ONE;
    end else if (out_fire) begin
      state_nxt = EMPTY;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_tag  <= '0;
    end else begin
      state <= state_nxt;
      if (load_main) begin
        main_data <= main_data_nxt;
        main_tag  <= main_tag_nxt;
      end
    end
  end

  // Deliberately survives flush: it measures downstream back-pressure, not stage contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage.sv
// Scoreboard bench for pipe_stage: the driver pushes accepted transfers into a queue, the monitor
// pops and compares whenever the stage presents an output fire. Works for both build variants.
module tb_pipe_stage;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 5;
  localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              flush = 1'b0;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  stall_cnt;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  entry_t           exp_q[$];
  int               cur_occ = 0;
  logic             exp_in_ready = 1'b1;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [TAG_W-1:0] next_tag = '0;
  int               checks = 0;
  int               failures = 0;

  pipe_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .flush(flush), .occ(occ), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkReset(input string tagname);
    check({tagname, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tagname, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tagname, "_out_data"}, out_data, 64'(0));
    check({tagname, "_out_tag"}, 64'(out_tag), 64'(0));
    check({tagname, "_occ"}, 64'(occ), 64'(0));
    check({tagname, "_stall_cnt"}, 64'(stall_cnt), 64'(0));
  endtask

  // One cycle of stimulus; the model's occupancy decides whether the transfer is accepted
  task automatic applyStimulus(input logic iv, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    cur_occ      = exp_q.size();
    exp_in_ready = (CAP == 2) ? (cur_occ < 2) : (cur_occ == 0 || ordy);
    in_valid     = iv;
    in_data      = {$urandom, $urandom};
    in_tag       = next_tag;
    out_ready    = ordy;
    flush        = fl;
    if (iv && exp_in_ready && !fl) begin
      exp_q.push_back('{data: in_data, tag: next_tag});
      next_tag = next_tag + TAG_W'(1);
    end
  endtask

  task automatic checkOutput();
    entry_t e;
    check("occ", 64'(occ), 64'(cur_occ));
    check("out_valid", 64'(out_valid), 64'(cur_occ != 0));
    check("in_ready", 64'(in_ready), 64'(exp_in_ready));
    check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: got tag %0h expected none at %0t", out_tag, $time);
      end else begin
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_tag", 64'(out_tag), 64'(e.tag));
      end
    end
    if (flush) exp_q.delete();
    if (cur_occ != 0 && !out_ready && exp_stall != '1) exp_stall = exp_stall + CNT_W'(1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) checkOutput();
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1 checkReset("por");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

    // back-pressure: fill, stall, then drain in order
    repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

    // flush while full with input offered, then flush discarding a live input fire
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0);

    // stall counter saturation
    repeat (20) applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, (i % 2) == 0, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-stream with one entry held
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1 checkReset("mid");
    exp_q.delete();
    exp_stall = '0;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    flush        = 1'b0;
    cur_occ      = 0;
    exp_in_ready = 1'b1;
    rst          = 1'b0;

    for (int i = 0; i < 300; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) > 1, $urandom_range(0, 19) == 0);
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
